// File: rtl/ex_muldiv_pkg.sv
// Shared EX-stage definitions: funct codes for the ALU and the mul/div unit,
// mul/div FSM state encoding and the latched operation control word.
package ex_muldiv_pkg;

  localparam int FUNCT_W = 6;

  // ALU funct codes
  localparam logic [FUNCT_W-1:0] FUNCT_SLL   = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL   = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA   = 6'h03;
  localparam logic [FUNCT_W-1:0] FUNCT_JR    = 6'h08;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU  = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU  = 6'h23;
  localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR   = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR   = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'h2A;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU  = 6'h2B;

  // Mul/div and HI/LO move funct codes
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  // Mul/div FSM state encoding
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MD_IDLE,
    ST_CALC = MD_CALC,
    ST_FIX  = MD_FIX
  } md_state_e;

  // Latched per-operation control: what to do at fix-up time
  typedef struct packed {
    logic is_div;  // divide (else multiply)
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder
    logic div0;    // divisor was zero: force quotient to all ones
  } md_ctl_t;

  // True for the four multi-cycle operations
  function automatic logic is_md_op(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_md_iter_step.sv
// One radix-2 iteration on the 2W-bit accumulator.
// Multiply: acc = {partial, multiplier}; add multiplicand if lsb set, shift right.
// Divide:   acc = {remainder, dividend}; shift left, trial-subtract divisor,
//           keep the difference and set the quotient bit when it does not borrow.
module md_iter_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc_in,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_out
);

  logic [W:0]     sum;
  logic [W+1:0]   diff;
  logic [2*W-1:0] shl;

  // Both candidate steps are computed; is_div selects
  always_comb begin
    sum  = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, operand} : {(W+1){1'b0}});
    shl  = {acc_in[2*W-2:0], 1'b0};
    // shifted-up remainder is W+1 bits wide; one extra bit holds the borrow
    diff = {1'b0, acc_in[2*W-1:W-1]} - {2'b00, operand};
    if (is_div) begin
      if (!diff[W+1]) acc_out = {diff[W-1:0], shl[W-1:1], 1'b1};
      else            acc_out = shl;
    end else begin
      acc_out = {sum, acc_in[W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning HI/LO. Operands are reduced to
// magnitudes at accept time, iterated unsigned for DATA_WIDTH cycles, and the
// signs are reapplied in a single fix-up cycle that commits HI/LO.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] md_result
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  md_state_e            state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc;
  logic [2*W-1:0]       acc_step;
  logic [W-1:0]         opnd;
  md_ctl_t              ctl;

  logic                 signed_op, is_div_req, op1_neg, op2_neg;
  logic [W-1:0]         mag1, mag2;
  logic [2*W-1:0]       prod_f;
  logic [W-1:0]         quo, rem, quo_f, rem_f;
  logic [W-1:0]         hi_nxt, lo_nxt;

  // Request decode and operand magnitudes (most negative maps to 2^(W-1))
  always_comb begin
    signed_op  = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    is_div_req = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    op1_neg    = signed_op & operand_1[W-1];
    op2_neg    = signed_op & operand_2[W-1];
    mag1       = op1_neg ? (~operand_1 + 1'b1) : operand_1;
    mag2       = op2_neg ? (~operand_2 + 1'b1) : operand_2;
  end

  md_iter_step #(.W(W)) u_step (
    .is_div  (ctl.is_div),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (acc_step)
  );

  // Sign fix-up of the finished unsigned result
  always_comb begin
    prod_f = ctl.neg_q ? (~acc + 1'b1) : acc;
    quo    = acc[W-1:0];
    rem    = acc[2*W-1:W];
    quo_f  = ctl.div0 ? {W{1'b1}} : (ctl.neg_q ? (~quo + 1'b1) : quo);
    rem_f  = ctl.neg_r ? (~rem + 1'b1) : rem;
    if (ctl.is_div) begin
      hi_nxt = rem_f;
      lo_nxt = quo_f;
    end else begin
      hi_nxt = prod_f[2*W-1:W];
      lo_nxt = prod_f[W-1:0];
    end
  end

  // MFHI/MFLO read path, no bypass of in-flight writes
  always_comb begin
    if      (funct == FUNCT_MFHI) md_result = hi;
    else if (funct == FUNCT_MFLO) md_result = lo;
    else                          md_result = '0;
  end

  // Control FSM, iteration counter, datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      ctl   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            if (is_md_op(funct)) begin
              acc        <= is_div_req ? {{W{1'b0}}, mag1} : {{W{1'b0}}, mag2};
              opnd       <= is_div_req ? mag2 : mag1;
              ctl.is_div <= is_div_req;
              ctl.neg_q  <= op1_neg ^ op2_neg;
              ctl.neg_r  <= is_div_req & op1_neg;
              ctl.div0   <= is_div_req && (operand_2 == '0);
              cnt        <= '0;
              state      <= ST_CALC;
              busy       <= 1'b1;
            end else if (funct == FUNCT_MTHI) begin
              hi <= operand_1;
            end else if (funct == FUNCT_MTLO) begin
              lo <= operand_1;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_step;
            if (cnt == LAST) state <= ST_FIX;
            else             cnt   <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          if (!flush) begin
            hi   <= hi_nxt;
            lo   <= lo_nxt;
            done <= 1'b1;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a transaction-level model (plain 64-bit arithmetic and
// a remaining-latency count) checked every cycle, plus literal result checks.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [5:0]    funct = FUNCT_SLL;
  logic [W-1:0]  op1 = '0, op2 = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo, md_result;

  int nvec = 0;
  int nerr = 0;

  ex_muldiv #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct     (funct),
    .operand_1 (op1),
    .operand_2 (op2),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .md_result (md_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} from integer arithmetic
  function automatic logic [2*W-1:0] md_model(input logic [5:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb;
    logic [2*W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f)
      FUNCT_MULTU: r = {32'h0, a} * {32'h0, b};
      FUNCT_MULT:  r = 64'(sa * sb);
      FUNCT_DIV:   if (b == 0) r = {a, 32'hFFFFFFFF};
                   else        r = {32'(sa % sb), 32'(sa / sb)};
      FUNCT_DIVU:  if (b == 0) r = {a, 32'hFFFFFFFF};
                   else        r = {a % b, a / b};
      default:     r = '0;
    endcase
    return r;
  endfunction

  // Model: remaining busy cycles, pending result, HI/LO
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [2*W-1:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        if (flush) m_cnt = 0;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin
            {m_hi, m_lo} = m_pend;
            m_done = 1'b1;
          end
        end
      end else if (start && !flush) begin
        if (funct == FUNCT_MULT || funct == FUNCT_MULTU ||
            funct == FUNCT_DIV  || funct == FUNCT_DIVU) begin
          m_pend = md_model(funct, op1, op2);
          m_cnt  = W + 1;
        end else if (funct == FUNCT_MTHI) m_hi = op1;
        else if (funct == FUNCT_MTLO) m_lo = op1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    chk("busy", 32'(busy), 32'(m_cnt > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (m_cnt == 0)
      chk("md_result", md_result,
          (funct == FUNCT_MFHI) ? m_hi : (funct == FUNCT_MFLO) ? m_lo : '0);
  end

  // One-cycle start pulse; returns at the negedge after the accept edge
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    funct = f; op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct = FUNCT_MFLO;
  endtask

  // Full operation with literal expectations checked in the done cycle
  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    issue(f, a, b);
    repeat (W + 1) @(posedge clk);
    #1;
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back operations, each accepted on the previous done cycle
    run_op("multu_max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", FUNCT_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg", FUNCT_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb", FUNCT_DIV, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("mult_min", FUNCT_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("divu_7", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_z", FUNCT_DIVU, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_z", FUNCT_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI then MFHI, no busy
    @(negedge clk);
    funct = FUNCT_MTHI; op1 = 32'hA5A5A5A5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct = FUNCT_MFHI;
    #1;
    chk("mfhi", md_result, 32'hA5A5A5A5);
    chk("mthi_busy", 32'(busy), 32'h0);

    // Non mul/div funct with start: no state change
    @(negedge clk);
    funct = FUNCT_ADDU; op1 = 32'h13579BDF; op2 = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("addu_hi", hi, 32'hA5A5A5A5);
    chk("addu_lo", lo, 32'h80000000);
    chk("addu_busy", 32'(busy), 32'h0);

    // Flush mid-CALC keeps HI/LO
    issue(FUNCT_MTHI, 32'h1, 32'h0);
    issue(FUNCT_MTLO, 32'h2, 32'h0);
    issue(FUNCT_MULT, 32'h5, 32'h6);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_hi", hi, 32'h1);
    chk("flush_lo", lo, 32'h2);
    repeat (40) @(negedge clk);

    // flush with start in IDLE: nothing written
    funct = FUNCT_MTHI; op1 = 32'hDEADBEEF; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_hi", hi, 32'h1);

    // start while busy is ignored
    issue(FUNCT_MULTU, 32'h10000, 32'h10000);
    funct = FUNCT_MTLO; op1 = 32'h77; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0; funct = FUNCT_MFLO;
    repeat (W - 4) @(posedge clk);
    #1;
    chk("busy_start_done", 32'(done), 32'd1);
    chk("busy_start_hi", hi, 32'h1);
    chk("busy_start_lo", lo, 32'h0);

    // Asynchronous reset mid-CALC
    issue(FUNCT_MULT, 32'h3, 32'h3);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", FUNCT_MULTU, 32'h3, 32'h5, 32'h0, 32'hF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
